ascon_perm_scheduler: RTL and testbench

- Arbitrates one shared, externally instantiated, single-round Ascon permutation unit between two requesters: requester 0 (initialization) and requester 1 (finalization, which feeds key-XORed state and takes the p12 result for tag generation).
- Accepts a 320-bit state from the granted requester and iterates the round unit once per cycle for ROUNDS cycles.
- Holds the permuted state until the owning requester accepts it.

---
 rtl/ascon_perm_scheduler.sv | 124 ++++++++++++
 tb/tb_ascon_perm_scheduler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_perm_scheduler.sv
// Shares one single-round Ascon permutation unit between two requesters (round-robin on ties).
// Optional busy-cycle performance counter: define ASCON_PERM_SCHED_BUSY_CNT_EN.
//
// state | meaning
// IDLE  | waiting for a job; grant is computed combinationally and the winner is accepted
// RUN   | one round per cycle through the external round unit, ROUNDS cycles
// DONE  | permuted state held on res_state until the owner takes it
module ascon_perm_scheduler #(
  parameter int ROUNDS = 12,
  parameter int CNT_W  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [319:0] req0_state,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [319:0] req1_state,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         res_id,
  output logic [319:0] res_state,
  output logic [319:0] round_state_o,
  output logic [7:0]   round_const_o,
  input  logic [319:0] round_state_i,
  output logic         busy,
  output logic [31:0]  busy_cycles
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } fsm_t;

  // Shorter jobs use the tail of the p12 constant schedule.
  localparam logic [3:0] R_OFS = 4'(12 - ROUNDS);

  fsm_t             fsm_q, fsm_d;
  logic [319:0]     st_q;
  logic [CNT_W-1:0] cnt_q;
  logic             res_id_q;
  logic             last_grant_q;
  logic             grant;
  logic             accept;
  logic             last_round;
  logic [3:0]       r_idx;

  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant_q;
    else if (req1_valid)          grant = 1'b1;
  end

  assign req0_ready = (fsm_q == S_IDLE) && req0_valid && !grant;
  assign req1_ready = (fsm_q == S_IDLE) && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;
  assign last_round = (cnt_q == CNT_W'(ROUNDS - 1));

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      S_IDLE:  if (accept)     fsm_d = S_RUN;
      S_RUN:   if (last_round) fsm_d = S_DONE;
      S_DONE:  if (res_ready)  fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
  end

  assign r_idx = R_OFS + 4'(cnt_q);

  always_comb begin
    round_const_o = 8'h00;
    if (fsm_q == S_RUN) round_const_o = {4'hF - r_idx, r_idx};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q        <= S_IDLE;
      st_q         <= '0;
      cnt_q        <= '0;
      res_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      fsm_q <= fsm_d;
      case (fsm_q)
        S_IDLE: begin
          if (accept) begin
            st_q         <= grant ? req1_state : req0_state;
            cnt_q        <= '0;
            res_id_q     <= grant;
            last_grant_q <= grant;
          end
        end
        S_RUN: begin
          st_q  <= round_state_i;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy          = (fsm_q != S_IDLE);
  assign res_valid     = (fsm_q == S_DONE);
  assign res_state     = st_q;
  assign res_id        = res_id_q;
  assign round_state_o = st_q;

`ifdef ASCON_PERM_SCHED_BUSY_CNT_EN
  logic [31:0] busy_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                           busy_cnt_q <= '0;
    else if (busy && busy_cnt_q != '1) busy_cnt_q <= busy_cnt_q + 32'd1;
  end

  assign busy_cycles = busy_cnt_q;
`else
  assign busy_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_ascon_perm_scheduler.sv
// Scoreboard bench for ascon_perm_scheduler: random traffic on a 12-round instance plus a directed 6-round job.
module tb_ascon_perm_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [319:0] req0_state, req1_state;
  logic         res_valid, res_ready, res_id, busy;
  logic [319:0] res_state, round_state_o, round_state_i;
  logic [7:0]   round_const_o;
  logic [31:0]  busy_cycles;

  logic         v6, rdy6, r1rdy6, resv6, resr6, resid6, busy6;
  logic [319:0] st6, ress6, rso6, rsi6;
  logic [7:0]   rc6;
  logic [31:0]  bc6;

  // Test round units: add the round constant (12-round) or add 1 (6-round).
  assign round_state_i = round_state_o + {312'd0, round_const_o};
  assign rsi6          = rso6 + 320'd1;

  ascon_perm_scheduler #(.ROUNDS(12), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_state(req0_state),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_state(req1_state),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_state(res_state),
    .round_state_o(round_state_o), .round_const_o(round_const_o), .round_state_i(round_state_i),
    .busy(busy), .busy_cycles(busy_cycles)
  );

  ascon_perm_scheduler #(.ROUNDS(6), .CNT_W(4)) u_dut6 (
    .clk(clk), .rst(rst),
    .req0_valid(v6), .req0_ready(rdy6), .req0_state(st6),
    .req1_valid(1'b0), .req1_ready(r1rdy6), .req1_state(320'd0),
    .res_valid(resv6), .res_ready(resr6), .res_id(resid6), .res_state(ress6),
    .round_state_o(rso6), .round_const_o(rc6), .round_state_i(rsi6),
    .busy(busy6), .busy_cycles(bc6)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [319:0] rand320();
    logic [319:0] v;
    for (int i = 0; i < 10; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  localparam int R12 = 12;

  // Reference: ROUNDS rounds of "add round constant", constants {F-r, r} for r = 12-ROUNDS..11.
  function automatic logic [319:0] ref_perm(input logic [319:0] s);
    logic [319:0] acc;
    acc = s;
    for (int r = 12 - R12; r < 12; r++) acc = acc + 320'((15 - r) * 16 + r);
    return acc;
  endfunction

  typedef struct packed {
    logic         id;
    logic [319:0] st;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        sb_e;
  int          m_phase;   // 0 idle, 1 running, 2 holding result
  int          m_k;
  logic        m_last;
  int unsigned m_bcnt;
  logic        m_g, m_e0, m_e1;
  logic [7:0]  m_const;
  int          m_r;

  // Reference model and monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_k     = 0;
      m_last  = 1'b1;
      m_bcnt  = 0;
      sb_q.delete();
    end else begin
      if (req0_valid && req1_valid) m_g = ~m_last;
      else                          m_g = req1_valid;
      m_e0 = (m_phase == 0) && req0_valid && !m_g;
      m_e1 = (m_phase == 0) && req1_valid && m_g;
      chk("req0_ready", req0_ready, m_e0);
      chk("req1_ready", req1_ready, m_e1);
      chk("busy", busy, m_phase != 0);
      chk("res_valid", res_valid, m_phase == 2);
`ifdef ASCON_PERM_SCHED_BUSY_CNT_EN
      chk("busy_cycles", busy_cycles, m_bcnt);
`else
      chk("busy_cycles", busy_cycles, 0);
`endif
      m_const = 8'h00;
      if (m_phase == 1) begin
        m_r     = 12 - R12 + m_k;
        m_const = 8'((15 - m_r) * 16 + m_r);
      end
      chk("round_const", round_const_o, m_const);

      if (res_valid && res_ready) begin
        if (sb_q.size() == 0) chk("result_expected", 1'b1, 1'b0);
        else begin
          sb_e = sb_q.pop_front();
          chk("res_id", res_id, sb_e.id);
          chk("res_state", res_state, sb_e.st);
        end
      end

      if (m_phase != 0) m_bcnt++;
      case (m_phase)
        0: if (m_e0 || m_e1) begin
             sb_q.push_back({m_g, ref_perm(m_g ? req1_state : req0_state)});
             m_phase = 1;
             m_k     = 0;
             m_last  = m_g;
           end
        1: begin
             m_k++;
             if (m_k == R12) m_phase = 2;
           end
        default: if (res_ready) m_phase = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [319:0] saved;
  logic [7:0]   tbl6 [6];

  initial begin
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; res_ready = 0;
    req0_state = '0; req1_state = '0;
    v6 = 0; st6 = '0; resr6 = 0;
    tbl6[0] = 8'h96; tbl6[1] = 8'h87; tbl6[2] = 8'h78;
    tbl6[3] = 8'h69; tbl6[4] = 8'h5A; tbl6[5] = 8'h4B;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_res_state", res_state, 0);
    chk("rst_const", round_const_o, 0);
    chk("rst_busy_cycles", busy_cycles, 0);

    // Two back-to-back jobs, result taken immediately.
    req0_valid = 1; req0_state = rand320(); res_ready = 1;
    repeat (15) tick();
    req0_valid = 0;
    repeat (13) tick();
`ifdef ASCON_PERM_SCHED_BUSY_CNT_EN
    chk("b2b_busy_cycles", busy_cycles, 26);
`else
    chk("b2b_busy_cycles", busy_cycles, 0);
`endif
    chk("b2b_idle", busy, 0);

    // Result held while res_ready is low; req1 waits meanwhile.
    saved = rand320();
    req0_valid = 1; req0_state = saved; res_ready = 0;
    tick();
    req0_valid = 0; req1_valid = 1; req1_state = rand320();
    repeat (12) tick();
    for (int i = 0; i < 5; i++) begin
      chk("hold_res_valid", res_valid, 1);
      chk("hold_res_state", res_state, ref_perm(saved));
      chk("hold_no_accept", req1_ready, 0);
      tick();
    end
    chk("hold_res_valid_end", res_valid, 1);
    res_ready = 1;
    tick();
    chk("after_hs_accept", req1_ready, 1);
    tick();
    req1_valid = 0;
    repeat (20) tick();

    // Reset in the middle of a req0 job: job dropped, req0 wins next tie.
    req0_valid = 1; req0_state = rand320();
    tick();
    req0_valid = 0;
    repeat (4) tick();
    rst = 1;
    tick();
    rst = 0;
    chk("midrst_busy", busy, 0);
    chk("midrst_res_valid", res_valid, 0);
    req0_valid = 1; req1_valid = 1;
    #1;
    chk("midrst_tie_req0", req0_ready, 1);
    chk("midrst_tie_req1", req1_ready, 0);

    // Both held: round-robin alternation.
    for (int i = 0; i < 60; i++) begin
      req0_state = rand320(); req1_state = rand320();
      tick();
    end

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_state = rand320(); req1_state = rand320();
      res_ready  = ($urandom_range(0, 2) != 0);
      tick();
    end
    req0_valid = 0; req1_valid = 0; res_ready = 1;
    repeat (20) tick();
    chk("scoreboard_drained", 32'(sb_q.size()), 0);

    // Six-round instance, +1 round unit.
    saved = rand320();
    v6 = 1; st6 = saved; resr6 = 1;
    #1;
    chk("r6_ready", rdy6, 1);
    tick();
    v6 = 0; st6 = rand320();
    for (int k = 0; k < 6; k++) begin
      chk("r6_const", rc6, tbl6[k]);
      chk("r6_no_early_valid", resv6, 0);
      tick();
    end
    chk("r6_res_valid", resv6, 1);
    chk("r6_res_state", ress6, saved + 320'd6);
    chk("r6_res_id", resid6, 0);
    tick();
    chk("r6_idle", busy6, 0);
`ifdef ASCON_PERM_SCHED_BUSY_CNT_EN
    chk("r6_busy_cycles", bc6, 7);
`else
    chk("r6_busy_cycles", bc6, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
